// File: rtl/matrix_mult_mkn.sv
// Sequential M x K by K x N matrix multiplier, one MAC per enabled cycle.
// Signed/unsigned operands, wrap/saturate output and a clip flag.
module matrix_mult_mkn #(
  parameter int M     = 2,
  parameter int K     = 2,
  parameter int N     = 2,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  signed_md,
  input  logic                  sat_md,
  input  logic [M*K*IN_W-1:0]   A,
  input  logic [K*N*IN_W-1:0]   B,
  output logic [M*N*OUT_W-1:0]  C,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  ovf
);

  localparam int ACC_W = 2*IN_W + $clog2(K) + 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] ML = IW'(M-1);
  localparam logic [JW-1:0] NL = JW'(N-1);
  localparam logic [KW-1:0] KL = KW'(K-1);
  localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W-1);
  localparam logic [OUT_W-1:0] SMAX = ~SMIN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  state_t state;

  logic [M*K*IN_W-1:0]  a_r;
  logic [K*N*IN_W-1:0]  b_r;
  logic                 sgn_r;
  logic                 sat_r;
  logic [IW-1:0]        i;
  logic [JW-1:0]        j;
  logic [KW-1:0]        k;
  logic [ACC_W-1:0]     acc;
  logic [M*N*OUT_W-1:0] stage;
  logic                 ovf_tmp;

  logic [IN_W-1:0]         a_el;
  logic [IN_W-1:0]         b_el;
  logic [ACC_W-1:0]        ax;
  logic [ACC_W-1:0]        bx;
  logic [ACC_W-1:0]        prod;
  logic [ACC_W-1:0]        acc_n;
  logic signed [ACC_W-1:0] sh;
  logic                    fits;
  logic [OUT_W-1:0]        cval;

  // Operands are extended to ACC_W first; the low ACC_W product bits
  // are exact for both signed and unsigned inputs.
  always_comb begin
    a_el  = a_r[(i*K+k)*IN_W +: IN_W];
    b_el  = b_r[(k*N+j)*IN_W +: IN_W];
    ax    = sgn_r ? {{(ACC_W-IN_W){a_el[IN_W-1]}}, a_el}
                  : {{(ACC_W-IN_W){1'b0}}, a_el};
    bx    = sgn_r ? {{(ACC_W-IN_W){b_el[IN_W-1]}}, b_el}
                  : {{(ACC_W-IN_W){1'b0}}, b_el};
    prod  = ax * bx;
    acc_n = acc + prod;
    sh    = $signed(acc_n) >>> (OUT_W-1);
    if (sgn_r)
      fits = (sh == '0) || (sh == '1);
    else
      fits = (acc_n >> OUT_W) == '0;
    cval = acc_n[OUT_W-1:0];
    if (sat_r && !fits) begin
      if (sgn_r)
        cval = acc_n[ACC_W-1] ? SMIN : SMAX;
      else
        cval = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sgn_r   <= 1'b0;
      sat_r   <= 1'b0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      acc     <= '0;
      stage   <= '0;
      ovf_tmp <= 1'b0;
      C       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            sgn_r   <= signed_md;
            sat_r   <= sat_md;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            ovf_tmp <= 1'b0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (abort) begin
            busy  <= 1'b0;
            valid <= 1'b0;
            state <= S_IDLE;
          end else if (en) begin
            if (k == KL) begin
              stage[(i*N+j)*OUT_W +: OUT_W] <= cval;
              ovf_tmp <= ovf_tmp | ~fits;
              acc     <= '0;
              k       <= '0;
              if (j == NL) begin
                j <= '0;
                if (i == ML)
                  state <= S_WRITE;
                else
                  i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              acc <= acc_n;
              k   <= k + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (abort) begin
            busy  <= 1'b0;
            valid <= 1'b0;
          end else begin
            C     <= stage;
            ovf   <= ovf_tmp;
            done  <= 1'b1;
            valid <= 1'b1;
            busy  <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_mkn.sv
// Bench for matrix_mult_mkn (2x3 by 3x4): arithmetic reference model
// with a per-cycle compare, directed literal cases and random jobs.
module tb_matrix_mult_mkn;

  localparam int M = 2;
  localparam int K = 3;
  localparam int N = 4;
  localparam int IN_W = 8;
  localparam int OUT_W = 8;
  localparam int AW = M*K*IN_W;
  localparam int BW = K*N*IN_W;
  localparam int CW = M*N*OUT_W;
  localparam int MNK = M*N*K;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          en = 1'b1;
  logic          abort = 1'b0;
  logic          signed_md = 1'b0;
  logic          sat_md = 1'b0;
  logic [AW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic [CW-1:0] C;
  logic          busy;
  logic          done;
  logic          valid;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  matrix_mult_mkn #(
    .M(M), .K(K), .N(N), .IN_W(IN_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .en(en),
    .abort(abort), .signed_md(signed_md), .sat_md(sat_md),
    .A(A), .B(B), .C(C), .busy(busy), .done(done),
    .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chkb(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkv(string nm, logic [CW-1:0] got, logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chki(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain integer matrix product, then clamp or wrap.
  function automatic void model(input logic [AW-1:0] a,
                                input logic [BW-1:0] b,
                                input logic sg, input logic st,
                                output logic [CW-1:0] c,
                                output logic o);
    longint s, av, bv, lo, hi, v, mod;
    o = 1'b0;
    c = '0;
    mod = longint'(1) << OUT_W;
    if (sg) begin
      lo = -(longint'(1) << (OUT_W-1));
      hi = (longint'(1) << (OUT_W-1)) - 1;
    end else begin
      lo = 0;
      hi = mod - 1;
    end
    for (int r = 0; r < M; r++) begin
      for (int cc = 0; cc < N; cc++) begin
        s = 0;
        for (int kk = 0; kk < K; kk++) begin
          av = longint'(a[(r*K+kk)*IN_W +: IN_W]);
          bv = longint'(b[(kk*N+cc)*IN_W +: IN_W]);
          if (sg && av >= 128) av -= 256;
          if (sg && bv >= 128) bv -= 256;
          s += av * bv;
        end
        if (st) begin
          v = (s > hi) ? hi : ((s < lo) ? lo : s);
        end else begin
          v = s & (mod - 1);
          if (sg && v > hi) v -= mod;
        end
        if (v != s) o = 1'b1;
        c[(r*N+cc)*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
    end
  endfunction

  logic          m_busy = 1'b0;
  int            m_rem = 0;
  logic          e_done = 1'b0;
  logic          e_valid = 1'b0;
  logic          e_ovf = 1'b0;
  logic [CW-1:0] e_c = '0;
  logic [CW-1:0] p_c = '0;
  logic          p_ovf = 1'b0;

  // Job-level timing: accept, count enabled MAC cycles, one write cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_rem = 0;
      e_done = 1'b0;
      e_valid = 1'b0;
      e_ovf = 1'b0;
      e_c = '0;
    end else begin
      e_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          model(A, B, signed_md, sat_md, p_c, p_ovf);
          m_busy = 1'b1;
          m_rem = MNK;
          e_valid = 1'b0;
        end
      end else if (abort) begin
        m_busy = 1'b0;
        e_valid = 1'b0;
      end else if (m_rem > 0) begin
        if (en) m_rem--;
      end else begin
        e_c = p_c;
        e_ovf = p_ovf;
        e_done = 1'b1;
        e_valid = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chkb("busy", busy, m_busy);
      chkb("done", done, e_done);
      chkb("valid", valid, e_valid);
      chkv("C", C, e_c);
      chkb("ovf", ovf, e_ovf);
    end
  end

  function automatic int c_el(int r, int c);
    return int'(C[(r*N+c)*OUT_W +: OUT_W]);
  endfunction

  task automatic set_a(int r, int c, int v);
    A[(r*K+c)*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic set_b(int r, int c, int v);
    B[(r*N+c)*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic start_job(logic sg, logic st);
    signed_md = sg;
    sat_md = st;
    en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: en high, 1: en toggles, 2: en random
  task automatic wait_done(int mode, bit noise, output int lat);
    lat = 0;
    while (!done && lat < 400) begin
      if (mode == 0) en = 1'b1;
      else if (mode == 1) en = ~en;
      else en = 1'($urandom_range(0, 1));
      if (noise) begin
        A = AW'({$urandom, $urandom});
        B = BW'({$urandom, $urandom, $urandom});
        signed_md = 1'($urandom_range(0, 1));
        sat_md = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    en = 1'b1;
    chkb("done_seen", done, 1'b1);
  endtask

  logic [CW-1:0] six;
  int lat;

  initial begin
    for (int e = 0; e < M*N; e++) six[e*OUT_W +: OUT_W] = 8'd6;
    repeat (2) @(negedge clk);
    chkv("rst_C", C, '0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_valid", valid, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_ovf", ovf, 1'b0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // A=[1 2 0;3 4 0], B = identity in the top-left corner
    A = '0; B = '0;
    set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
    set_b(0, 0, 1); set_b(1, 1, 1);
    start_job(1'b0, 1'b0);
    wait_done(0, 1'b0, lat);
    chki("t1_latency", lat, MNK + 1);
    chki("t1_c00", c_el(0, 0), 1);
    chki("t1_c01", c_el(0, 1), 2);
    chki("t1_c10", c_el(1, 0), 3);
    chki("t1_c11", c_el(1, 1), 4);
    chki("t1_c03", c_el(0, 3), 0);
    chkb("t1_ovf", ovf, 1'b0);
    @(negedge clk);
    chkb("t1_done_pulse", done, 1'b0);

    // (-128)*(-128)*2 = 32768 saturates to 127, wraps to 0
    A = '0; B = '0;
    set_a(0, 0, 128); set_a(0, 1, 128);
    set_b(0, 0, 128); set_b(1, 0, 128);
    start_job(1'b1, 1'b1);
    wait_done(0, 1'b0, lat);
    chki("t2_sat_c00", c_el(0, 0), 127);
    chki("t2_sat_c11", c_el(1, 1), 0);
    chkb("t2_sat_ovf", ovf, 1'b1);
    start_job(1'b1, 1'b0);
    wait_done(0, 1'b0, lat);
    chki("t2_wrap_c00", c_el(0, 0), 0);
    chkb("t2_wrap_ovf", ovf, 1'b1);

    // all ones by all twos, then back-to-back all threes
    A = '0; B = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++) set_a(r, c, 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++) set_b(r, c, 2);
    start_job(1'b0, 1'b0);
    wait_done(0, 1'b0, lat);
    chki("t3_latency", lat, 25);
    chkv("t3_all6", C, six);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++) set_b(r, c, 3);
    start_job(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chkv("t6_hold_first", C, six);
    wait_done(0, 1'b0, lat);
    chki("t6_second_c12", c_el(1, 2), 9);
    chki("t6_latency", lat, MNK + 1);

    // en toggling each cycle with mid-job input noise and start pulses
    A = AW'({$urandom, $urandom});
    B = BW'({$urandom, $urandom, $urandom});
    start_job(1'b1, 1'b0);
    wait_done(1, 1'b1, lat);
    chki("t4_latency", lat, 2*MNK);

    for (int n = 0; n < 12; n++) begin
      A = AW'({$urandom, $urandom});
      B = BW'({$urandom, $urandom, $urandom});
      start_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(int'($urandom_range(0, 2)), 1'b1, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // abort at MAC cycle 3, abort in IDLE, then reset mid-job
    A = AW'({$urandom, $urandom});
    start_job(1'b0, 1'b1);
    en = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chkb("t5_abort_busy", busy, 1'b0);
    chkb("t5_abort_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_job(1'b1, 1'b0);
    en = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chkv("t5_rst_C", C, '0);
    chkb("t5_rst_busy", busy, 1'b0);
    chkb("t5_rst_valid", valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chkb("t5_no_done", done, 1'b0);

    A = AW'({$urandom, $urandom});
    B = BW'({$urandom, $urandom, $urandom});
    start_job(1'b1, 1'b1);
    wait_done(0, 1'b0, lat);
    chki("final_latency", lat, MNK + 1);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
